// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: serial-to-byte receiver for the UART boot-load path.
// Recovers 8N1 frames (8E1 when UART_RX_PARITY_EN is defined) from io_rx and
// presents each good byte as a one-cycle strobe. Bad frames are flagged and dropped.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   io_rx         raw serial line (asynchronous, idle high)
//   byte_valid    one-cycle strobe, byte_data holds a new good byte
//   byte_data     last good byte (LSB = first data bit), held between strobes
//   framing_error one-cycle strobe, stop bit sampled low
//   parity_error  one-cycle strobe, even-parity mismatch (0 without parity build)
//   busy          high whenever the receiver is not idle
//
// Build option: define UART_RX_PARITY_EN for 8E1 frames with parity checking.
module uart_rx_deserializer #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       io_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       framing_error,
  output logic       parity_error,
  output logic       busy
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);

  // Bit period too short to find the middle of the start bit.
  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
      $error("uart_rx_deserializer: CLKS_PER_BIT must be >= 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             rx_meta, rx_s;
  logic             byte_valid_n, framing_error_n, busy_n;
  logic [7:0]       byte_data_n;
`ifdef UART_RX_PARITY_EN
  logic             par_bad, par_bad_n;
  logic             parity_error_n;
`endif

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= io_rx;
      rx_s    <= rx_meta;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      byte_valid    <= 1'b0;
      byte_data     <= '0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad       <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      bit_idx       <= bit_idx_n;
      shreg         <= shreg_n;
      byte_valid    <= byte_valid_n;
      byte_data     <= byte_data_n;
      framing_error <= framing_error_n;
      busy          <= busy_n;
`ifdef UART_RX_PARITY_EN
      par_bad       <= par_bad_n;
      parity_error  <= parity_error_n;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_error = 1'b0;
`endif

  // Next-state, datapath and strobe logic.
  always_comb begin
    state_n         = state;
    cnt_n           = cnt + CNT_W'(1);
    bit_idx_n       = bit_idx;
    shreg_n         = shreg;
    byte_valid_n    = 1'b0;
    byte_data_n     = byte_data;
    framing_error_n = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n       = par_bad;
    parity_error_n  = 1'b0;
`endif

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end

      // Re-check the line mid start bit to reject glitches.
      START: begin
        if (cnt == START_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end
      end

      // Shift in from the top so the first bit ends up at bit 0.
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          shreg_n   = {rx_s, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      // Even parity: data plus parity bit must have an even number of ones.
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          par_bad_n = ^{shreg, rx_s};
          state_n   = STOP;
        end
      end
`endif

      // A low stop bit wins over a parity mismatch.
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (!rx_s) begin
            framing_error_n = 1'b1;
            state_n         = WAIT_IDLE;
          end else begin
            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad) begin
              parity_error_n = 1'b1;
            end else begin
              byte_valid_n = 1'b1;
              byte_data_n  = shreg;
            end
`else
            byte_valid_n = 1'b1;
            byte_data_n  = shreg;
`endif
          end
        end
      end

      // Hold off until the line returns high so a break flags only once.
      WAIT_IDLE: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end

      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer at CLKS_PER_BIT = 16.
// Works for both the 8N1 build and the UART_RX_PARITY_EN (8E1) build.
module tb_uart_rx_deserializer;

  localparam int unsigned N = 16;
  localparam int unsigned H = N / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int NB     = 11;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int NB     = 10;
`endif
  localparam int STOP_IDX = NB - 1;

  localparam int EV_VALID = 0;
  localparam int EV_FE    = 1;
  localparam int EV_PE    = 2;
  localparam int K_PE     = PAR_EN ? EV_PE : EV_VALID;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    int         gap;
    int         exp_kind;
    logic [7:0] exp_data;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic       io_rx;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       framing_error;
  logic       parity_error;
  logic       busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_rise = -1;
  int   busy_fall = -1;
  bit   busy_q = 1'b0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];
  logic [7:0] last_good;

  uart_rx_deserializer #(.CLKS_PER_BIT(N)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .io_rx         (io_rx),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .framing_error (framing_error),
    .parity_error  (parity_error),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Observe strobes and busy edges away from the active edge.
  always @(negedge clk) begin
    ev_t o;
    if (byte_valid) begin
      o.kind = EV_VALID; o.cyc = cyc; o.data = byte_data; obs_q.push_back(o);
    end
    if (framing_error) begin
      o.kind = EV_FE; o.cyc = cyc; o.data = 8'h00; obs_q.push_back(o);
    end
    if (parity_error) begin
      o.kind = EV_PE; o.cyc = cyc; o.data = 8'h00; obs_q.push_back(o);
    end
    if (busy && !busy_q) busy_rise = cyc;
    if (!busy && busy_q) busy_fall = cyc;
    busy_q = busy;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame; p is the cycle the start bit was put on the pin.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                            output int p);
    logic [10:0] frame;
    frame = PAR_EN ? {stop, pbit, d, 1'b0} : {1'b1, stop, d, 1'b0};
    p = cyc;
    for (int i = 0; i < NB; i++) begin
      io_rx = frame[i];
      repeat (N) tick();
    end
  endtask

  // Reference: outcome of a frame from its bits, strobe one cycle after mid stop bit.
  function automatic ev_t model_frame(input logic [7:0] d, input logic pbit,
                                      input logic stop, input int p);
    ev_t e;
    e.cyc  = p + 2 + H + STOP_IDX * N + 1;
    e.data = 8'h00;
    if (!stop)
      e.kind = EV_FE;
    else if (PAR_EN && ((($countones(d) + int'(pbit)) % 2) != 0))
      e.kind = EV_PE;
    else begin
      e.kind = EV_VALID;
      e.data = d;
    end
    return e;
  endfunction

  task automatic check_events(input string tag);
    ev_t e, o;
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_kind"}, 32'(o.kind), 32'(e.kind));
      chk({tag, "_cyc"},  32'(o.cyc),  32'(e.cyc));
      chk({tag, "_data"}, 32'(o.data), 32'(e.data));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    vec_t vecs[10];
    ev_t  e;
    int   p;
    logic [7:0] d;
    logic pb, st;
    int   gap;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 5, EV_VALID, 8'hA5};
    vecs[1] = '{8'h11, 1'b0, 1'b1, 0, EV_VALID, 8'h11};
    vecs[2] = '{8'h11, 1'b0, 1'b1, 0, EV_VALID, 8'h11};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 0, EV_VALID, 8'h00};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 4, EV_VALID, 8'hFF};
    vecs[5] = '{8'h3C, 1'b0, 1'b0, 3, EV_FE,    8'h00};
    vecs[6] = '{8'h42, 1'b0, 1'b1, 3, EV_VALID, 8'h42};
    vecs[7] = '{8'h07, 1'b1, 1'b1, 3, EV_VALID, 8'h07};
    vecs[8] = '{8'h07, 1'b0, 1'b1, 3, K_PE,     (K_PE == EV_VALID) ? 8'h07 : 8'h00};
    vecs[9] = '{8'h80, 1'b0, 1'b0, 3, EV_FE,    8'h00};

    reset_n = 1'b0;
    io_rx   = 1'b1;
    repeat (3) tick();
    chk("rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte_data", 32'(byte_data), 32'h00);
    chk("rst_framing_error", 32'(framing_error), 32'd0);
    chk("rst_parity_error", 32'(parity_error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    last_good = 8'h00;

    // Idle line after reset
    repeat (1000) tick();
    check_events("idle");
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_byte_data", 32'(byte_data), 32'h00);

    // Directed frame table
    for (int i = 0; i < 10; i++) begin
      send_frame(vecs[i].data, vecs[i].pbit, vecs[i].stop, p);
      e.kind = vecs[i].exp_kind;
      e.cyc  = p + 3 + H + STOP_IDX * N;
      e.data = vecs[i].exp_data;
      exp_q.push_back(e);
      check_events($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_busy_rise", i), 32'(busy_rise), 32'(p + 3));
      if (vecs[i].exp_kind != EV_FE)
        chk($sformatf("vec%0d_busy_fall", i), 32'(busy_fall), 32'(e.cyc));
      if (vecs[i].exp_kind == EV_VALID) last_good = vecs[i].exp_data;
      io_rx = 1'b1;
      repeat (vecs[i].gap) tick();
    end
    repeat (4) tick();
    chk("table_byte_data_hold", 32'(byte_data), 32'(last_good));

    // Short low glitch is rejected in START
    p = cyc;
    io_rx = 1'b0;
    repeat (5) tick();
    io_rx = 1'b1;
    repeat (30) tick();
    check_events("glitch");
    chk("glitch_busy_rise", 32'(busy_rise), 32'(p + 3));
    chk("glitch_busy", 32'(busy), 32'd0);
    chk("glitch_byte_data", 32'(byte_data), 32'(last_good));

    // Low stop bit followed by a held-low line
    send_frame(8'h3C, 1'b0, 1'b0, p);
    exp_q.push_back(model_frame(8'h3C, 1'b0, 1'b0, p));
    repeat (50) tick();
    chk("break_busy_wait", 32'(busy), 32'd1);
    check_events("break");
    gap = cyc;
    io_rx = 1'b1;
    repeat (4) tick();
    chk("break_busy_fall", 32'(busy_fall), 32'(gap + 3));
    chk("break_busy", 32'(busy), 32'd0);
    send_frame(8'h42, 1'b0, 1'b1, p);
    exp_q.push_back(model_frame(8'h42, 1'b0, 1'b1, p));
    check_events("after_break");
    last_good = 8'h42;

    // Randomized frames against the reference model
    for (int i = 0; i < 40; i++) begin
      d   = 8'($urandom_range(0, 255));
      pb  = 1'($urandom_range(0, 1));
      st  = ($urandom_range(0, 7) != 0);
      gap = st ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 4));
      send_frame(d, pb, st, p);
      e = model_frame(d, pb, st, p);
      exp_q.push_back(e);
      if (e.kind == EV_VALID) last_good = e.data;
      check_events($sformatf("rnd%0d", i));
      io_rx = 1'b1;
      repeat (gap) tick();
    end
    repeat (4) tick();
    chk("rnd_byte_data_hold", 32'(byte_data), 32'(last_good));

    // Reset in the middle of the data bits
    io_rx = 1'b0;
    repeat (N + H + 3 * N) tick();
    chk("midrst_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #2;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_byte_valid", 32'(byte_valid), 32'd0);
    chk("midrst_byte_data", 32'(byte_data), 32'h00);
    io_rx = 1'b1;
    tick();
    reset_n = 1'b1;
    repeat (12 * N) tick();
    check_events("midrst");
    chk("midrst_busy_after", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
